// File: rtl/rnd_lfsr_ctrl.sv
// Sequencer and feedback generator for the random shift-register stage.
// It loads a seed, shifts SHIFTS steps per word and hands each word downstream over valid/ready.
module rnd_lfsr_ctrl #(
    parameter int              WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter int              SHIFTS   = 8,
    parameter logic [WIDTH-1:0] SEED_SUB = 8'h01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [7:0]       num_words,
    input  logic             abort,
    input  logic [WIDTH-1:0] sr_out,
    output logic [WIDTH-1:0] sr_seed,
    output logic             sr_init,
    output logic             sr_en,
    output logic             sr_fb,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, PRESENT} state_t;

    localparam logic [7:0] STEP_LAST = 8'(SHIFTS - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] seed_q;
    logic [7:0]       step_q;
    logic [8:0]       words_left_q;
    logic             done_q;

    assign sr_fb   = ^(sr_out & TAPS);
    assign sr_seed = seed_q;
    assign done    = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sr_init   = 1'b0;
        sr_en     = 1'b0;
        rnd_valid = 1'b0;
        rnd_data  = '0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                sr_init   = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                sr_en = 1'b1;
                if (step_q == STEP_LAST) state_nxt = PRESENT;
            end
            PRESENT: begin
                rnd_valid = 1'b1;
                rnd_data  = sr_out;
                if (rnd_ready) state_nxt = (words_left_q == 9'd1) ? IDLE : SHIFT;
            end
            default: state_nxt = IDLE;
        endcase
        // abort wins over start and over a same-cycle handshake
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q       <= '0;
            step_q       <= '0;
            words_left_q <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            step_q <= (state == SHIFT && state_nxt == SHIFT) ? step_q + 8'd1 : 8'd0;
            if (state == IDLE && start && !abort) begin
                seed_q       <= (seed_in == '0) ? SEED_SUB : seed_in;
                words_left_q <= (num_words == 8'd0) ? 9'd256 : {1'b0, num_words};
            end
            if (state == PRESENT && rnd_ready && !abort) begin
                words_left_q <= words_left_q - 9'd1;
                if (words_left_q == 9'd1) done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rnd_lfsr_ctrl.sv
// Bench for rnd_lfsr_ctrl with a shift-register stage attached; expected words come from a
// queue filled by stepping the feedback polynomial, checked on every handshake.
module tb_rnd_lfsr_ctrl;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, rnd_ready = 1'b0;
    logic [7:0] seed_in = '0, num_words = '0;
    logic [7:0] sr_out, sr_seed, rnd_data;
    logic       sr_init, sr_en, sr_fb, rnd_valid, busy, done;
    logic [7:0] sr;

    always #5 clk = ~clk;

    rnd_lfsr_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_in(seed_in), .num_words(num_words),
        .abort(abort), .sr_out(sr_out), .sr_seed(sr_seed), .sr_init(sr_init), .sr_en(sr_en),
        .sr_fb(sr_fb), .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .busy(busy), .done(done)
    );

    // shift-register stage: load on init, shift left with feedback into bit 0
    assign sr_out = sr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       sr <= '0;
        else if (sr_init) sr <= sr_seed;
        else if (sr_en)   sr <= {sr[6:0], sr_fb};
    end

    int         errors = 0, checks = 0, hs_cnt = 0;
    logic [7:0] exp_q[$];
    bit         done_exp = 1'b0, prev_stall = 1'b0, done_nxt;
    logic [7:0] prev_data;

    task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        logic p = 1'b0;
        for (int b = 0; b < 8; b++) if (8'hB8 & (8'h01 << b)) p = p ^ x[b];
        return {x[6:0], p};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] seed, input logic [7:0] n);
        logic [7:0] s;
        int cnt;
        s   = (seed == 8'h00) ? 8'h01 : seed;
        cnt = (n == 8'd0) ? 256 : int'(n);
        for (int k = 0; k < cnt; k++) begin
            for (int j = 0; j < 8; j++) s = lfsr_next(s);
            exp_q.push_back(s);
        end
        seed_in = seed; num_words = n; start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            cyc(1);
            seen = done;
        end
        chk_eq(nm, seen, 1);
    endtask

    // compare process: every word, done timing and output invariants
    always @(negedge clk) begin
        if (!rst_n) begin
            done_exp   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            done_nxt = 1'b0;
            chk_eq("init_en_excl", sr_init & sr_en, 0);
            chk_eq("done_pulse", done, done_exp);
            if (!rnd_valid) chk_eq("data_idle", rnd_data, 0);
            else begin
                chk_eq("en_in_present", sr_en, 0);
                if (prev_stall) chk_eq("stall_stable", rnd_data, prev_data);
            end
            if (sr_en || rnd_valid) chk_eq("sr_nonzero", sr_out != 8'h00, 1);
            if (rnd_valid && rnd_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) chk_eq("extra_word", exp_q.size(), 1);
                else begin
                    chk_eq("word", rnd_data, exp_q.pop_front());
                    done_nxt = (exp_q.size() == 0);
                end
            end
            prev_stall = rnd_valid && !rnd_ready;
            prev_data  = rnd_data;
            done_exp   = done_nxt;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int hs0;
        bit got;

        // reset state
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_valid", rnd_valid, 0);
        chk_eq("rst_seed", sr_seed, 0);
        chk_eq("rst_en", sr_en, 0);

        // single word from seed 01, latency and done pulse
        rnd_ready = 1'b1;
        launch(8'h01, 8'd1);
        chk_eq("load_init", sr_init, 1);
        chk_eq("load_seed", sr_seed, 8'h01);
        chk_eq("load_busy", busy, 1);
        cyc(8);
        chk_eq("lat_not_yet", rnd_valid, 0);
        cyc(1);
        chk_eq("lat_valid", rnd_valid, 1);
        chk_eq("first_word", rnd_data, 8'h1C);
        cyc(1);
        chk_eq("done_after", done, 1);
        chk_eq("busy_fall", busy, 0);
        cyc(1);
        chk_eq("done_one_cycle", done, 0);

        // reset in the middle of SHIFT
        launch(8'h5A, 8'd2);
        cyc(4);
        chk_eq("mid_shift_en", sr_en, 1);
        rst_n = 1'b0;
        #1;
        chk_eq("arst_en", sr_en, 0);
        chk_eq("arst_init", sr_init, 0);
        chk_eq("arst_valid", rnd_valid, 0);
        chk_eq("arst_busy", busy, 0);
        chk_eq("arst_done", done, 0);
        chk_eq("arst_seed", sr_seed, 0);
        chk_eq("arst_data", rnd_data, 0);
        exp_q.delete();
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        launch(8'h01, 8'd1);
        cyc(9);
        chk_eq("post_rst_word", rnd_data, 8'h1C);
        wait_done(5, "post_rst_done");

        // zero seed substitution, 256 words
        cyc(1);
        hs0 = hs_cnt;
        launch(8'h00, 8'd0);
        chk_eq("zero_seed_sub", sr_seed, 8'h01);
        cyc(9);
        chk_eq("zero_first_word", rnd_data, 8'h1C);
        wait_done(3000, "done_256");
        chk_eq("count_256", hs_cnt - hs0, 256);
        chk_eq("idle_256", busy, 0);

        // three words with 5-cycle stalls each
        cyc(1);
        rnd_ready = 1'b0;
        hs0 = hs_cnt;
        launch(8'hC3, 8'd3);
        for (int w = 0; w < 3; w++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                if (rnd_valid) got = 1'b1;
                else cyc(1);
            end
            chk_eq("stall_wait_valid", got, 1);
            for (int s = 0; s < 5; s++) begin
                cyc(1);
                chk_eq("stall_hold", rnd_valid, 1);
                chk_eq("stall_en_low", sr_en, 0);
            end
            rnd_ready = 1'b1;
            cyc(1);
            rnd_ready = 1'b0;
        end
        chk_eq("stall_done", done, 1);
        chk_eq("stall_count", hs_cnt - hs0, 3);

        // abort in 4th SHIFT cycle with start high
        cyc(1);
        rnd_ready = 1'b1;
        hs0 = hs_cnt;
        launch(8'h33, 8'd2);
        cyc(4);
        chk_eq("abort_in_shift", sr_en, 1);
        abort = 1'b1; start = 1'b1; seed_in = 8'h77; num_words = 8'd1;
        cyc(1);
        abort = 1'b0; start = 1'b0;
        exp_q.delete();
        chk_eq("abort_busy", busy, 0);
        chk_eq("abort_en", sr_en, 0);
        chk_eq("abort_init", sr_init, 0);
        chk_eq("abort_done", done, 0);
        cyc(1);
        chk_eq("abort_start_ignored", busy, 0);
        cyc(12);
        chk_eq("abort_no_words", hs_cnt - hs0, 0);

        // start pulses while busy must not disturb the run
        launch(8'hA5, 8'd3);
        cyc(3);
        seed_in = 8'h11; num_words = 8'd1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(6);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_done(100, "busy_start_done");
        chk_eq("busy_start_seed", sr_seed, 8'hA5);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
